mem_store_buffer: RTL and testbench

- Parametrised write-back store buffer between the MEM stage and the DCache CPU port.
- Committed stores are queued here and drained to the cache with a valid/ready handshake, so MEM no longer stalls on store misses.
- Loads issued from MEM look up the buffer and get youngest-first byte forwarding.
- Successor to the single-request direct DCache hookup; adds configurable depth and width, forwarding, uncached ordering and a drain request.

---
 rtl/mem_store_buffer_pkg.sv | 31 +++
 rtl/mem_store_buffer_forward_mux.sv | 51 +++++
 rtl/mem_store_buffer.sv | 191 +++++++++++++++++++
 tb/tb_mem_store_buffer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_store_buffer_pkg.sv
// Shared definitions for the MEM-stage store buffer.
// Provides lane geometry helpers and the default-geometry entry layout.
// Optional build macro: STORE_MERGE_EN (see mem_store_buffer.sv).
package mem_store_buffer_pkg;

   localparam int unsigned SB_ADDR_W = 32;
   localparam int unsigned SB_DATA_W = 32;

   // Byte lanes per data word.
   function automatic int unsigned sb_strb_w(input int unsigned data_w);
      return data_w / 8;
   endfunction

   // Address bits that select a byte within a word.
   function automatic int unsigned sb_ofs_w(input int unsigned data_w);
      return $clog2(data_w / 8);
   endfunction

   localparam int unsigned SB_STRB_W = sb_strb_w(SB_DATA_W);
   localparam int unsigned SB_OFS_W  = sb_ofs_w(SB_DATA_W);

   // One buffered store, default geometry; modules re-declare it at their own widths.
   typedef struct packed {
      logic                          valid;
      logic [SB_ADDR_W-SB_OFS_W-1:0] waddr;
      logic [SB_DATA_W-1:0]          data;
      logic [SB_STRB_W-1:0]          strb;
      logic                          uncached;
   } sb_entry_t;

endpackage

// File: rtl/mem_store_buffer_forward_mux.sv
// Load-forwarding select: per byte lane, picks data from the youngest
// occupied entry whose word matches the load and whose strobe covers the lane.
// Ports: i_ld_valid/i_ld_waddr load lookup; i_valid/i_waddr/i_data/i_strb
// entry fields; i_head/i_tail wrap-bit pointers; o_data/o_strb forwarded bytes.
module mem_store_buffer_forward_mux
   import mem_store_buffer_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned WADDR_W = 30,
   parameter int unsigned DATA_W  = 32
)(
   input  logic                      i_ld_valid,
   input  logic [WADDR_W-1:0]        i_ld_waddr,
   input  logic                      i_valid [DEPTH],
   input  logic [WADDR_W-1:0]        i_waddr [DEPTH],
   input  logic [DATA_W-1:0]         i_data  [DEPTH],
   input  logic [DATA_W/8-1:0]       i_strb  [DEPTH],
   input  logic [$clog2(DEPTH):0]    i_head,
   input  logic [$clog2(DEPTH):0]    i_tail,
   output logic [DATA_W-1:0]         o_data,
   output logic [DATA_W/8-1:0]       o_strb
);

   localparam int unsigned STRB_W = sb_strb_w(DATA_W);
   localparam int unsigned IDX_W  = $clog2(DEPTH);
   localparam int unsigned PTR_W  = IDX_W + 1;

   logic [PTR_W-1:0] w_cnt;
   logic [IDX_W-1:0] w_idx;

   // Walk oldest to youngest so later (younger) hits overwrite earlier ones.
   always_comb begin
      o_data = '0;
      o_strb = '0;
      w_idx  = '0;
      w_cnt  = i_tail - i_head;
      for (int i = 0; i < int'(DEPTH); i++) begin
         w_idx = i_head[IDX_W-1:0] + IDX_W'(i);
         if (i_ld_valid && (PTR_W'(i) < w_cnt) && i_valid[w_idx] &&
             (i_waddr[w_idx] == i_ld_waddr)) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
               if (i_strb[w_idx][b]) begin
                  o_data[8*b +: 8] = i_data[w_idx][8*b +: 8];
                  o_strb[b]        = 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/mem_store_buffer.sv
// Write-back store buffer between MEM and the DCache CPU port.
// Committed stores queue in a circular FIFO and drain over dc_valid/dc_ready;
// MEM loads get youngest-first byte forwarding plus a stall for uncached
// ordering and same-cycle store collisions.
// Ports: st_* store intake, dc_* head entry to DCache, ld_* load lookup,
// drain_req stops merging, empty/full/count occupancy.
// Optional build macro: STORE_MERGE_EN -- coalesce a cached store into the
// youngest entry of the same word instead of allocating a new one.
module mem_store_buffer
   import mem_store_buffer_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = SB_ADDR_W,
   parameter int unsigned DATA_W = SB_DATA_W
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   st_valid,
   output logic                   st_ready,
   input  logic [ADDR_W-1:0]      st_addr,
   input  logic [DATA_W-1:0]      st_wdata,
   input  logic [DATA_W/8-1:0]    st_wstrb,
   input  logic                   st_uncached,
   output logic                   dc_valid,
   input  logic                   dc_ready,
   output logic [ADDR_W-1:0]      dc_addr,
   output logic [DATA_W-1:0]      dc_wdata,
   output logic [DATA_W/8-1:0]    dc_wstrb,
   output logic                   dc_uncached,
   input  logic                   ld_valid,
   input  logic [ADDR_W-1:0]      ld_addr,
   input  logic                   ld_uncached,
   output logic [DATA_W-1:0]      ld_data,
   output logic [DATA_W/8-1:0]    ld_strb,
   output logic                   ld_stall,
   input  logic                   drain_req,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned STRB_W  = sb_strb_w(DATA_W);
   localparam int unsigned OFS_W   = sb_ofs_w(DATA_W);
   localparam int unsigned WADDR_W = ADDR_W - OFS_W;
   localparam int unsigned IDX_W   = $clog2(DEPTH);
   localparam int unsigned PTR_W   = IDX_W + 1;

   typedef struct packed {
      logic               valid;
      logic [WADDR_W-1:0] waddr;
      logic [DATA_W-1:0]  data;
      logic [STRB_W-1:0]  strb;
      logic               uncached;
   } entry_t;

   entry_t           r_entry [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic             r_merge_en;

   logic [IDX_W-1:0]   w_head_idx;
   logic [IDX_W-1:0]   w_tail_idx;
   logic [IDX_W-1:0]   w_young_idx;
   logic [WADDR_W-1:0] w_st_waddr;
   logic [WADDR_W-1:0] w_ld_waddr;
   logic               w_merge_en;
   logic               w_merge;
   logic               w_push;
   logic               w_pop;
   logic               w_hit_uc;
   logic               w_unused_ofs;

   logic               w_e_valid [DEPTH];
   logic [WADDR_W-1:0] w_e_waddr [DEPTH];
   logic [DATA_W-1:0]  w_e_data  [DEPTH];
   logic [STRB_W-1:0]  w_e_strb  [DEPTH];

   assign w_head_idx  = r_head[IDX_W-1:0];
   assign w_tail_idx  = r_tail[IDX_W-1:0];
   assign w_young_idx = w_tail_idx - IDX_W'(1);
   assign w_st_waddr  = st_addr[ADDR_W-1:OFS_W];
   assign w_ld_waddr  = ld_addr[ADDR_W-1:OFS_W];

   // Byte-offset bits only matter to the requester, not to word matching.
   assign w_unused_ofs = ^{st_addr[OFS_W-1:0], ld_addr[OFS_W-1:0]};

   assign empty = (r_head == r_tail);
   assign full  = (w_head_idx == w_tail_idx) && (r_head[IDX_W] != r_tail[IDX_W]);
   assign count = r_tail - r_head;

   // drain_req blocks merging immediately; re-enable lags its release by a cycle.
   assign w_merge_en = r_merge_en && !drain_req;

`ifdef STORE_MERGE_EN
   // Never merge into the head while it is offered: the DCache may be sampling it.
   assign w_merge = st_valid && w_merge_en && !st_uncached && !empty &&
                    r_entry[w_young_idx].valid && !r_entry[w_young_idx].uncached &&
                    (r_entry[w_young_idx].waddr == w_st_waddr) &&
                    !(dc_valid && (w_young_idx == w_head_idx));
`else
   logic w_unused_merge;
   assign w_unused_merge = ^{w_merge_en, w_young_idx};
   assign w_merge        = 1'b0;
`endif

   assign st_ready = !full || w_merge;
   assign w_push   = st_valid && !full && !w_merge;
   assign w_pop    = dc_valid && dc_ready;

   // Head entry presented to the DCache.
   assign dc_valid    = !empty;
   assign dc_addr     = {r_entry[w_head_idx].waddr, OFS_W'(0)};
   assign dc_wdata    = r_entry[w_head_idx].data;
   assign dc_wstrb    = r_entry[w_head_idx].strb;
   assign dc_uncached = r_entry[w_head_idx].uncached;

   // FIFO state, entry writes and merge-enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_merge_en <= 1'b1;
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_entry[i] <= '0;
         end
      end else begin
         r_merge_en <= !drain_req;
         if (w_pop) begin
            r_entry[w_head_idx].valid <= 1'b0;
            r_head                    <= r_head + PTR_W'(1);
         end
         if (w_push) begin
            r_entry[w_tail_idx] <= '{valid:    1'b1,
                                     waddr:    w_st_waddr,
                                     data:     st_wdata,
                                     strb:     st_wstrb,
                                     uncached: st_uncached};
            r_tail              <= r_tail + PTR_W'(1);
         end
         if (w_merge) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
               if (st_wstrb[b]) begin
                  r_entry[w_young_idx].data[8*b +: 8] <= st_wdata[8*b +: 8];
               end
            end
            r_entry[w_young_idx].strb <= r_entry[w_young_idx].strb | st_wstrb;
         end
      end
   end

   // Unpack entries for the forwarding mux.
   always_comb begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         w_e_valid[i] = r_entry[i].valid;
         w_e_waddr[i] = r_entry[i].waddr;
         w_e_data[i]  = r_entry[i].data;
         w_e_strb[i]  = r_entry[i].strb;
      end
   end

   mem_store_buffer_forward_mux #(
      .DEPTH   (DEPTH),
      .WADDR_W (WADDR_W),
      .DATA_W  (DATA_W)
   ) u_fwd (
      .i_ld_valid (ld_valid),
      .i_ld_waddr (w_ld_waddr),
      .i_valid    (w_e_valid),
      .i_waddr    (w_e_waddr),
      .i_data     (w_e_data),
      .i_strb     (w_e_strb),
      .i_head     (r_head),
      .i_tail     (r_tail),
      .o_data     (ld_data),
      .o_strb     (ld_strb)
   );

   // Any buffered uncached store to the load's word forces a stall.
   always_comb begin
      w_hit_uc = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (r_entry[i].valid && r_entry[i].uncached && (r_entry[i].waddr == w_ld_waddr)) begin
            w_hit_uc = 1'b1;
         end
      end
   end

   assign ld_stall = ld_valid && (w_hit_uc || (ld_uncached && !empty) ||
                                  (st_valid && (w_st_waddr == w_ld_waddr)));

endmodule

// File: tb/tb_mem_store_buffer.sv
// Directed self-checking bench for mem_store_buffer (DEPTH=4, 32-bit data).
module tb_mem_store_buffer;

`ifdef STORE_MERGE_EN
   localparam bit MERGE = 1'b1;
`else
   localparam bit MERGE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        st_valid, st_ready, st_uncached;
   logic [31:0] st_addr, st_wdata;
   logic [3:0]  st_wstrb;
   logic        dc_valid, dc_ready, dc_uncached;
   logic [31:0] dc_addr, dc_wdata;
   logic [3:0]  dc_wstrb;
   logic        ld_valid, ld_uncached, ld_stall;
   logic [31:0] ld_addr, ld_data;
   logic [3:0]  ld_strb;
   logic        drain_req, empty, full;
   logic [2:0]  count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
      .st_wdata(st_wdata), .st_wstrb(st_wstrb), .st_uncached(st_uncached),
      .dc_valid(dc_valid), .dc_ready(dc_ready), .dc_addr(dc_addr),
      .dc_wdata(dc_wdata), .dc_wstrb(dc_wstrb), .dc_uncached(dc_uncached),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_uncached(ld_uncached),
      .ld_data(ld_data), .ld_strb(ld_strb), .ld_stall(ld_stall),
      .drain_req(drain_req), .empty(empty), .full(full), .count(count)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle store offer that is expected to be accepted.
   task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic uc);
      st_valid = 1'b1; st_addr = a; st_wdata = d; st_wstrb = s; st_uncached = uc;
      tick();
      st_valid = 1'b0; st_uncached = 1'b0;
   endtask

   // Pop until empty with a bounded cycle budget.
   task automatic drain_all(input string tag);
      dc_ready = 1'b1;
      for (int i = 0; i < 10 && !empty; i++) tick();
      dc_ready = 1'b0;
      check(tag, empty, 1);
   endtask

   initial begin
      rst = 1'b1; st_valid = 0; st_addr = 0; st_wdata = 0; st_wstrb = 0; st_uncached = 0;
      dc_ready = 0; ld_valid = 0; ld_addr = 0; ld_uncached = 0; drain_req = 0;
      tick(); tick();
      rst = 1'b0;
      #1;
      check("rst_dc_valid", dc_valid, 0);
      check("rst_empty",    empty,    1);
      check("rst_full",     full,     0);
      check("rst_st_ready", st_ready, 1);
      check("rst_ld_strb",  ld_strb,  0);
      check("rst_ld_data",  ld_data,  0);
      check("rst_ld_stall", ld_stall, 0);
      check("rst_count",    count,    0);

      // Single store, latency 1, then pop.
      push(32'h100, 32'hAABBCCDD, 4'b1111, 1'b0);
      check("t1_dc_valid", dc_valid, 1);
      check("t1_dc_addr",  dc_addr,  32'h100);
      check("t1_dc_wdata", dc_wdata, 32'hAABBCCDD);
      check("t1_count",    count,    1);
      dc_ready = 1'b1;
      tick();
      dc_ready = 1'b0;
      check("t1_empty",    empty,    1);
      check("t1_dc_vld0",  dc_valid, 0);

      // Fill, hold fifth store, then push+pop at count 3.
      for (int i = 0; i < 4; i++) push(32'h10 + 32'(4*i), 32'(i + 1), 4'hF, 1'b0);
      check("t2_full",     full,     1);
      check("t2_count4",   count,    4);
      st_valid = 1'b1; st_addr = 32'h20; st_wdata = 32'h5; st_wstrb = 4'hF;
      #1;
      check("t2_st_ready", st_ready, 0);
      tick();
      check("t2_held",     count,    4);
      check("t2_head",     dc_addr,  32'h10);
      dc_ready = 1'b1;
      tick();
      check("t2_pop_full", count,    3);
      check("t2_head2",    dc_addr,  32'h14);
      check("t2_rdy3",     st_ready, 1);
      tick();
      st_valid = 1'b0; dc_ready = 1'b0;
      check("t2_pushpop",  count,    3);
      check("t2_head3",    dc_addr,  32'h18);
      drain_all("t2_drain");

      // Youngest-first byte forwarding.
      push(32'h200, 32'h11223344, 4'b0011, 1'b0);
      push(32'h202, 32'h55660000, 4'b1100, 1'b0);
      ld_valid = 1'b1; ld_addr = 32'h200;
      #1;
      check("t3_ld_data",  ld_data,  32'h55663344);
      check("t3_ld_strb",  ld_strb,  4'hF);
      check("t3_ld_stall", ld_stall, 0);
      ld_valid = 1'b0;
      push(32'h200, 32'h000000EE, 4'b0001, 1'b0);
      ld_valid = 1'b1; dc_ready = 1'b1;
      #1;
      check("t3_young",    ld_data,  32'h556633EE);
      check("t3_pop_strb", ld_strb,  4'hF);
      tick();
      ld_valid = 1'b0; dc_ready = 1'b0;
      drain_all("t3_drain");

      // Uncached ordering stalls.
      push(32'h1FD0_0000, 32'h1, 4'hF, 1'b1);
      check("t4_dc_uc",    dc_uncached, 1);
      ld_valid = 1'b1; ld_addr = 32'h1FD0_0000; ld_uncached = 1'b0;
      #1;
      check("t4_stall_uc", ld_stall, 1);
      dc_ready = 1'b1;
      tick();
      dc_ready = 1'b0;
      check("t4_unstall",  ld_stall, 0);
      ld_valid = 1'b0;
      push(32'h600, 32'h6, 4'hF, 1'b0);
      ld_valid = 1'b1; ld_addr = 32'h300; ld_uncached = 1'b1;
      #1;
      check("t4_stall_ord", ld_stall, 1);
      ld_uncached = 1'b0;
      #1;
      check("t4_no_stall", ld_stall, 0);
      check("t4_no_strb",  ld_strb,  0);
      ld_valid = 1'b0;
      drain_all("t4_drain");

      // Same-cycle store collision.
      st_valid = 1'b1; st_addr = 32'h400; st_wdata = 32'h4; st_wstrb = 4'hF;
      ld_valid = 1'b1; ld_addr = 32'h404;
      #1;
      check("t5_diff_word", ld_stall, 0);
      check("t5_diff_strb", ld_strb,  0);
      ld_addr = 32'h400;
      #1;
      check("t5_same_word", ld_stall, 1);
      ld_addr = 32'h402;
      #1;
      check("t5_same_byte", ld_stall, 1);
      st_valid = 1'b0; ld_valid = 1'b0;
      #1;

      // Reset while the head is offered.
      push(32'h800, 32'h8, 4'hF, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_rst_valid", dc_valid, 0);
      check("t6_rst_count", count,    0);

      // Merge with the head busy on another word, then with drain_req held.
      push(32'h700, 32'h7, 4'hF, 1'b0);
      push(32'h500, 32'h000000AA, 4'b0001, 1'b0);
      push(32'h500, 32'h0000BB00, 4'b0010, 1'b0);
      check("t7_count",     count, MERGE ? 3'd2 : 3'd3);
      dc_ready = 1'b1;
      tick();
      dc_ready = 1'b0;
      check("t7_dc_addr",   dc_addr,  32'h500);
      check("t7_dc_wstrb",  dc_wstrb, MERGE ? 4'b0011 : 4'b0001);
      check("t7_dc_wdata",  dc_wdata, MERGE ? 32'h0000BBAA : 32'h000000AA);
      drain_all("t7_drain");
      drain_req = 1'b1;
      tick();
      push(32'h700, 32'h7, 4'hF, 1'b0);
      push(32'h500, 32'h000000AA, 4'b0001, 1'b0);
      push(32'h500, 32'h0000BB00, 4'b0010, 1'b0);
      check("t8_count_drain", count, 3);
      drain_all("t8_drain");
      drain_req = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
